uart_tx_fifo: RTL and testbench

Transmit-side byte buffer and launcher placed directly upstream of the UART transmitter, in the transmitter's clock domain (`tx_clk`). Host logic pushes bytes at any rate up to one per cycle. The block stores them in a circular FIFO and feeds them one at a time to the transmitter's `data_in` / `tx_en` inputs. It paces each launch with the transmitter's `busy` handshake, so that frames go out back-to-back without host involvement.

---
 rtl/uart_tx_fifo.sv | 88 ++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter, one launch per busy handshake.
// Bytes are launched back-to-back; a launch that never sees busy rise is dropped and flagged.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int BUSY_TIMEOUT = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                  tx_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flush,
   input  logic                  tx_busy,
   output logic                  tx_en,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  full,
   output logic                  empty,
   output logic [AW:0]           count,
   output logic                  overflow,
   output logic                  launch_err,
   output logic                  sending
);
   localparam int TW = $clog2(BUSY_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, START, HOLD} state_t;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
   logic [TW-1:0] tmo, tmo_n;
   logic push, pop, tx_en_n, lerr_n;
   assign push = wr_en && !full && !flush;
   assign pop = (state == IDLE) && !empty && !tx_busy && !flush;
   assign wr_n = wr_ptr + {{AW{1'b0}}, push};
   assign rd_n = flush ? wr_ptr : rd_ptr + {{AW{1'b0}}, pop};
   assign count = wr_ptr - rd_ptr;
   assign sending = state != IDLE;
   always_ff @(posedge tx_clk)
      if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
   always_ff @(posedge tx_clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full <= 1'b0;
         empty <= 1'b1;
         overflow <= 1'b0;
         state <= IDLE;
         tmo <= '0;
         tx_en <= 1'b0;
         launch_err <= 1'b0;
         tx_data <= '0;
      end else begin
         wr_ptr <= wr_n;
         rd_ptr <= rd_n;
         full <= (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
         empty <= wr_n == rd_n;
         overflow <= wr_en && full;
         state <= state_n;
         tmo <= tmo_n;
         tx_en <= tx_en_n;
         launch_err <= lerr_n;
         if (pop) tx_data <= mem[rd_ptr[AW-1:0]];
      end
   always_comb begin
      state_n = state;
      tmo_n = tmo;
      tx_en_n = tx_en;
      lerr_n = 1'b0;
      case (state)
         IDLE:
            if (pop) begin
               state_n = START;
               tx_en_n = 1'b1;
               tmo_n = '0;
            end
         START:
            if (tx_busy) begin
               state_n = HOLD;
               tx_en_n = 1'b0;
            end else if (tmo == TW'(BUSY_TIMEOUT - 1)) begin
               state_n = IDLE;
               tx_en_n = 1'b0;
               lerr_n = 1'b1;
            end else tmo_n = tmo + TW'(1);
         HOLD: if (!tx_busy) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a simple transmitter busy model.
module tb_uart_tx_fifo;
   logic tx_clk, rst, wr_en, flush, busy_h, busy_m, tx_busy;
   logic [7:0] wr_data, tx_data;
   logic tx_en, full, empty, overflow, launch_err, sending;
   logic [4:0] count;
   logic [7:0] sb [$];
   int n_chk = 0, n_pass = 0, n_launch = 0, cyc = 0;
   int fall_cyc = -1, gap_start = 0, busy_dly = 1, busy_len = 50;
   bit auto_xmt = 0, gap_on = 0, prev_en = 0;
   assign tx_busy = busy_h | busy_m;

   uart_tx_fifo dut (
      .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
      .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .full(full), .empty(empty),
      .count(count), .overflow(overflow), .launch_err(launch_err), .sending(sending)
   );

   initial begin
      tx_clk = 0;
      forever #5 tx_clk = ~tx_clk;
   end
   always @(posedge tx_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // launch monitor: every rising tx_en pops the scoreboard
   always @(negedge tx_clk) begin
      if (!rst && tx_en && !prev_en) begin
         n_launch++;
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) chk("launch_data", tx_data, sb.pop_front());
         if (gap_on && fall_cyc > gap_start) chk("b2b_gap", cyc - fall_cyc, 2);
      end
      prev_en = tx_en;
   end

   initial begin
      busy_m = 0;
      forever begin
         @(negedge tx_clk);
         if (auto_xmt && tx_en) begin
            repeat (busy_dly) @(negedge tx_clk);
            busy_m = 1;
            repeat (busy_len) @(negedge tx_clk);
            busy_m = 0;
            fall_cyc = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic push_b(input logic [7:0] d, input bit keep);
      wr_en = 1;
      wr_data = d;
      if (keep) sb.push_back(d);
      @(negedge tx_clk);
      wr_en = 0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 2000 && (!empty || sending || tx_busy); i++) @(negedge tx_clk);
      chk(tag, {empty, sending}, 2'b10);
   endtask

   initial begin
      int l0, peak, hi;
      rst = 1; wr_en = 0; wr_data = 0; flush = 0; busy_h = 0;
      repeat (3) @(negedge tx_clk);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_launch_err", launch_err, 0);
      chk("rst_sending", sending, 0);
      rst = 0;
      repeat (6) @(negedge tx_clk);

      // single byte, manual busy
      push_b(8'h28, 1);
      chk("t1_en_early", tx_en, 0);
      chk("t1_empty", empty, 0);
      chk("t1_count1", count, 1);
      @(negedge tx_clk);
      chk("t1_en", tx_en, 1);
      chk("t1_count0", count, 0);
      chk("t1_sending", sending, 1);
      repeat (2) @(negedge tx_clk);
      chk("t1_en_hold", tx_en, 1);
      @(negedge tx_clk);
      busy_h = 1;
      @(negedge tx_clk);
      chk("t1_en_drop", tx_en, 0);
      chk("t1_hold_data", tx_data, 8'h28);
      chk("t1_hold_sending", sending, 1);
      repeat (19) @(negedge tx_clk);
      busy_h = 0;
      @(negedge tx_clk);
      chk("t1_idle", sending, 0);
      chk("t1_empty_end", empty, 1);

      // burst of three with transmitter model
      auto_xmt = 1; busy_dly = 1; busy_len = 50; gap_on = 1; gap_start = cyc;
      l0 = n_launch;
      push_b(8'h28, 1);
      push_b(8'h55, 1);
      push_b(8'h7B, 1);
      peak = count;
      for (int i = 0; i < 400 && (!empty || sending || tx_busy); i++) begin
         @(negedge tx_clk);
         if (count > peak) peak = count;
      end
      chk("t2_peak", peak, 2);
      chk("t2_launches", n_launch - l0, 3);
      chk("t2_empty", empty, 1);
      gap_on = 0; auto_xmt = 0;
      @(negedge tx_clk);

      // full / overflow with busy stuck high, then drain across wrap
      busy_h = 1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) begin
            chk("t3_not_full", full, 0);
            chk("t3_count15", count, 15);
         end
         push_b(8'(i + 1), 1);
      end
      chk("t3_full", full, 1);
      chk("t3_count16", count, 16);
      chk("t3_no_ovf", overflow, 0);
      push_b(8'h99, 0);
      chk("t3_overflow", overflow, 1);
      chk("t3_count_keep", count, 16);
      chk("t3_full_keep", full, 1);
      @(negedge tx_clk);
      chk("t3_ovf_pulse", overflow, 0);
      l0 = n_launch;
      auto_xmt = 1; busy_dly = 1; busy_len = 5;
      busy_h = 0;
      wait_idle("t3_drain_idle");
      chk("t3_drain_n", n_launch - l0, 16);
      auto_xmt = 0;
      @(negedge tx_clk);

      // launch timeout
      push_b(8'hA5, 1);
      @(negedge tx_clk);
      chk("t4_en", tx_en, 1);
      hi = 0;
      while (tx_en && hi < 200) begin
         hi++;
         @(negedge tx_clk);
      end
      chk("t4_en_cycles", hi, 64);
      chk("t4_launch_err", launch_err, 1);
      chk("t4_idle", sending, 0);
      chk("t4_count", count, 0);
      @(negedge tx_clk);
      chk("t4_err_pulse", launch_err, 0);

      // flush while a frame is in flight
      push_b(8'h3C, 1);
      @(negedge tx_clk);
      chk("t5_en", tx_en, 1);
      busy_h = 1;
      @(negedge tx_clk);
      chk("t5_hold", tx_en, 0);
      for (int i = 0; i < 5; i++) push_b(8'(8'h60 + i), 0);
      chk("t5_count5", count, 5);
      flush = 1; wr_en = 1; wr_data = 8'hEE;
      @(negedge tx_clk);
      flush = 0; wr_en = 0;
      chk("t5_count0", count, 0);
      chk("t5_empty", empty, 1);
      chk("t5_tx_data", tx_data, 8'h3C);
      chk("t5_sending", sending, 1);
      l0 = n_launch;
      busy_h = 0;
      repeat (10) @(negedge tx_clk);
      chk("t5_no_launch", n_launch, l0);
      chk("t5_idle", sending, 0);

      // asynchronous reset in HOLD
      push_b(8'h11, 1);
      @(negedge tx_clk);
      busy_h = 1;
      @(negedge tx_clk);
      push_b(8'h22, 0);
      chk("t6_pre_count", count, 1);
      chk("t6_pre_sending", sending, 1);
      #2 rst = 1;
      #1;
      chk("t6_rst_sending", sending, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_empty", empty, 1);
      chk("t6_rst_tx_en", tx_en, 0);
      @(negedge tx_clk);
      rst = 0;
      push_b(8'h33, 1);
      repeat (5) @(negedge tx_clk);
      chk("t6_no_launch", tx_en, 0);
      chk("t6_count", count, 1);
      busy_h = 0;
      @(negedge tx_clk);
      chk("t6_launch", tx_en, 1);
      busy_h = 1;
      repeat (3) @(negedge tx_clk);
      busy_h = 0;
      repeat (3) @(negedge tx_clk);
      chk("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
